// File: rtl/midi_note_encoder.sv
// Serialises one MIDI note-on/note-off request into status/data bytes with a ready/valid handshake.
// Optional build macro MIDI_RUNNING_STATUS_EN drops a repeated status byte (running status).
module midi_note_encoder #(
    parameter int IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       noteReq,
    input  logic       noteIsOn,
    input  logic [3:0] channel,
    input  logic [6:0] note,
    input  logic [6:0] velocity,
    input  logic       read,
    output logic       busy,
    output logic [7:0] message,
    output logic       dataValid
);
    typedef enum logic [2:0] {IDLE, STATUS, DATA1, DATA2, GAP} state_t;

    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [6:0]    lat_note;
    logic [6:0]    lat_vel;
    logic [7:0]    req_status;
    logic          xfer;
    logic          skip_status;

    assign req_status = {(noteIsOn ? 4'h9 : 4'h8), channel};
    assign xfer       = dataValid & read;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic       last_valid;
    assign skip_status = last_valid && (last_status == req_status);
`else
    assign skip_status = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dataValid <= 1'b0;
            message   <= 8'h00;
            gap_cnt   <= '0;
            lat_note  <= '0;
            lat_vel   <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status <= 8'h00;
            last_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (noteReq) begin
                        lat_note  <= note;
                        lat_vel   <= velocity;
                        busy      <= 1'b1;
                        dataValid <= 1'b1;
                        if (skip_status) begin
                            state   <= DATA1;
                            message <= {1'b0, note};
                        end else begin
                            state   <= STATUS;
                            message <= req_status;
                        end
                    end
                end
                STATUS: begin
                    if (xfer) begin
                        state   <= DATA1;
                        message <= {1'b0, lat_note};
`ifdef MIDI_RUNNING_STATUS_EN
                        last_status <= message;
                        last_valid  <= 1'b1;
`endif
                    end
                end
                DATA1: begin
                    if (xfer) begin
                        state   <= DATA2;
                        message <= {1'b0, lat_vel};
                    end
                end
                DATA2: begin
                    if (xfer) begin
                        dataValid <= 1'b0;
                        message   <= 8'h00;
                        gap_cnt   <= '0;
                        if (IDLE_GAP == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Counter runs 0..IDLE_GAP-1 so GAP lasts exactly IDLE_GAP cycles.
                    if (gap_cnt == GW'(IDLE_GAP - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    dataValid <= 1'b0;
                    message   <= 8'h00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_midi_note_encoder.sv
// Directed bench: stimulus pushes expected bytes into a queue, a monitor pops them on each transfer.
module tb_midi_note_encoder;
    logic       clk = 0;
    logic       rst = 0;
    logic       noteReq = 0, noteIsOn = 0, read = 0;
    logic [3:0] channel = 0;
    logic [6:0] note = 0, velocity = 0;
    logic       busy, dataValid;
    logic [7:0] message;

    int checks = 0;
    int errors = 0;
    logic [7:0] expq[$];

    midi_note_encoder #(.IDLE_GAP(2)) dut (
        .clk(clk), .rst(rst), .noteReq(noteReq), .noteIsOn(noteIsOn),
        .channel(channel), .note(note), .velocity(velocity), .read(read),
        .busy(busy), .message(message), .dataValid(dataValid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic on, input logic [3:0] ch, input logic [6:0] n, input logic [6:0] v);
        noteReq = 1; noteIsOn = on; channel = ch; note = n; velocity = v;
        tick();
        noteReq = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    // Monitor: a transfer is any sampled cycle with dataValid && read outside reset.
    always @(negedge clk) begin
        if (rst && dataValid && read) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte got %0h expected none at %0t", message, $time);
            end else begin
                chk("byte", message, expq.pop_front());
            end
        end
    end

    initial begin
        // Reset, with a request that must be ignored during reset.
        noteReq = 1; noteIsOn = 1; channel = 3; note = 7'h3C; velocity = 7'h64;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_dv", dataValid, 0);
        chk("rst_msg", message, 8'h00);
        noteReq = 0;
        rst = 1;
        tick();
        chk("post_rst_idle", busy, 0);

        // Note-on ch3 with read high; a second request while busy is dropped.
        read = 1;
        expq.push_back(8'h93); expq.push_back(8'h3C); expq.push_back(8'h64);
        request(1, 3, 7'h3C, 7'h64);
        chk("t1_status", message, 8'h93);
        chk("t1_dv", dataValid, 1);
        noteReq = 1; note = 7'h40; velocity = 7'h11;
        tick();
        noteReq = 0;
        chk("t1_note", message, 8'h3C);
        tick();
        chk("t1_vel", message, 8'h64);
        tick();
        chk("gap1_dv", dataValid, 0);
        chk("gap1_busy", busy, 1);
        chk("gap1_msg", message, 8'h00);
        tick();
        chk("gap2_busy", busy, 1);
        tick();
        chk("idle_busy", busy, 0);

        // Note-off ch0 with read stalled five cycles in DATA1.
        expq.push_back(8'h80); expq.push_back(8'h45); expq.push_back(8'h00);
        request(0, 0, 7'h45, 7'h00);
        chk("t2_status", message, 8'h80);
        tick();
        read = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_msg", message, 8'h45);
            chk("stall_dv", dataValid, 1);
            tick();
        end
        read = 1;
        tick();
        chk("t2_vel", message, 8'h00);
        chk("t2_vel_dv", dataValid, 1);
        tick();
        chk("t2_gap_dv", dataValid, 0);
        wait_idle("t2_idle");

        // Abort after the status byte: nothing more may follow.
        expq.push_back(8'h93);
        request(1, 3, 7'h3C, 7'h64);
        tick();
        chk("abort_pre_msg", message, 8'h3C);
        rst = 0;
        tick();
        chk("abort_dv", dataValid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_msg", message, 8'h00);
        rst = 1;
        repeat (6) tick();
        chk("abort_quiet", dataValid, 0);

        // Two note-ons on ch3; second drops its status byte only with running status.
        expq.push_back(8'h93); expq.push_back(8'h3C); expq.push_back(8'h64);
        request(1, 3, 7'h3C, 7'h64);
        wait_idle("rs1_idle");
`ifdef MIDI_RUNNING_STATUS_EN
        expq.push_back(8'h3E); expq.push_back(8'h64);
`else
        expq.push_back(8'h93); expq.push_back(8'h3E); expq.push_back(8'h64);
`endif
        request(1, 3, 7'h3E, 7'h64);
        wait_idle("rs2_idle");
        repeat (3) tick();

        chk("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
